// File: rtl/power_domain_sequencer.sv
// Power-domain sequencer for one gateable domain: idle detect, then
// isolate/save/switch-off, and on wake switch-on/restore/de-isolate.
module power_domain_sequencer #(
    parameter int IDLE_CYCLES = 16,
    parameter int ISO_SETUP   = 2,
    parameter int PSW_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       activity,
    input  logic       wake_req,
    input  logic       pwr_sw_ack,
    input  logic       err_clr,
    output logic       pwr_sw_en,
    output logic       iso_en,
    output logic       save,
    output logic       restore,
    output logic       domain_ready,
    output logic       err_flag,
    output logic [2:0] pstate
);

    localparam int IW = $clog2(IDLE_CYCLES + 1);
    localparam int SW = $clog2(ISO_SETUP + 1);
    localparam int TW = $clog2(PSW_TIMEOUT + 1);

    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
    localparam logic [SW-1:0] ISO_LAST  = SW'(ISO_SETUP - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(PSW_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_ON      = 3'd0,
        ST_ISO     = 3'd1,
        ST_SAVE    = 3'd2,
        ST_OFF_REQ = 3'd3,
        ST_OFF     = 3'd4,
        ST_ON_REQ  = 3'd5,
        ST_RESTORE = 3'd6,
        ST_DEISO   = 3'd7
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [IW-1:0]   idle_cnt;
    logic [SW-1:0]   iso_cnt;
    logic [TW-1:0]   to_cnt;
    logic            wake_pend;
    logic            wake_any;
    logic            idle_done;
    logic            timeout;

    assign wake_any  = activity | wake_req;
    assign idle_done = (state == ST_ON) && !wake_any && (idle_cnt == IDLE_LAST);
    // A timeout only counts while the ack still disagrees with the switch command.
    assign timeout   = (to_cnt == TO_LAST) &&
                       (((state == ST_OFF_REQ) && pwr_sw_ack) ||
                        ((state == ST_ON_REQ) && !pwr_sw_ack));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_ON;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_ON:      if (idle_done) state_next = ST_ISO;
            ST_ISO: begin
                if (wake_any)                  state_next = ST_DEISO;
                else if (iso_cnt == ISO_LAST)  state_next = ST_SAVE;
            end
            ST_SAVE:    state_next = ST_OFF_REQ;
            ST_OFF_REQ: begin
                if (!pwr_sw_ack)   state_next = ST_OFF;
                else if (timeout)  state_next = ST_ON_REQ;
            end
            ST_OFF:     if (wake_any || wake_pend) state_next = ST_ON_REQ;
            ST_ON_REQ:  if (pwr_sw_ack) state_next = ST_RESTORE;
            ST_RESTORE: state_next = ST_DEISO;
            ST_DEISO:   state_next = ST_ON;
            default:    state_next = ST_ON;
        endcase
    end

    always_comb begin
        pwr_sw_en    = 1'b1;
        iso_en       = 1'b1;
        save         = 1'b0;
        restore      = 1'b0;
        domain_ready = 1'b0;
        case (state)
            ST_ON: begin
                iso_en       = 1'b0;
                domain_ready = 1'b1;
            end
            ST_SAVE:            save      = 1'b1;
            ST_OFF_REQ, ST_OFF: pwr_sw_en = 1'b0;
            ST_RESTORE:         restore   = 1'b1;
            default:            ;
        endcase
    end

    assign pstate = state;

    // Counters restart on every state change, so each wait starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
            iso_cnt  <= '0;
            to_cnt   <= '0;
        end else begin
            if ((state == ST_ON) && !wake_any && !idle_done) begin
                idle_cnt <= idle_cnt + IW'(1);
            end else begin
                idle_cnt <= '0;
            end

            if ((state == ST_ISO) && (state_next == ST_ISO)) begin
                iso_cnt <= iso_cnt + SW'(1);
            end else begin
                iso_cnt <= '0;
            end

            if ((state_next == state) && !timeout &&
                ((state == ST_OFF_REQ) || (state == ST_ON_REQ))) begin
                to_cnt <= to_cnt + TW'(1);
            end else begin
                to_cnt <= '0;
            end
        end
    end

    // A wake arriving too late to abort is remembered and honoured once OFF is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wake_pend <= 1'b0;
            err_flag  <= 1'b0;
        end else begin
            if (state_next == ST_ON_REQ) begin
                wake_pend <= 1'b0;
            end else if (((state == ST_SAVE) || (state == ST_OFF_REQ)) && wake_any) begin
                wake_pend <= 1'b1;
            end

            if (timeout) begin
                err_flag <= 1'b1;
            end else if (err_clr) begin
                err_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_power_domain_sequencer.sv
// Directed bench for power_domain_sequencer: each step queues the expected
// Moore outputs, clocks once, then pops and compares them against the DUT.
`timescale 1ns/1ps
module tb_power_domain_sequencer;

    localparam logic [2:0] S_ON      = 3'd0;
    localparam logic [2:0] S_ISO     = 3'd1;
    localparam logic [2:0] S_SAVE    = 3'd2;
    localparam logic [2:0] S_OFF_REQ = 3'd3;
    localparam logic [2:0] S_OFF     = 3'd4;
    localparam logic [2:0] S_ON_REQ  = 3'd5;
    localparam logic [2:0] S_RESTORE = 3'd6;
    localparam logic [2:0] S_DEISO   = 3'd7;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       activity;
    logic       wake_req;
    logic       pwr_sw_ack;
    logic       err_clr;
    logic       pwr_sw_en;
    logic       iso_en;
    logic       save;
    logic       restore;
    logic       domain_ready;
    logic       err_flag;
    logic [2:0] pstate;

    logic [8:0] exp_q[$];
    int         tests_run    = 0;
    int         tests_failed = 0;

    power_domain_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .activity     (activity),
        .wake_req     (wake_req),
        .pwr_sw_ack   (pwr_sw_ack),
        .err_clr      (err_clr),
        .pwr_sw_en    (pwr_sw_en),
        .iso_en       (iso_en),
        .save         (save),
        .restore      (restore),
        .domain_ready (domain_ready),
        .err_flag     (err_flag),
        .pstate       (pstate)
    );

    always #5 clk = ~clk;

    // Output vector {pstate, pwr_sw_en, iso_en, save, restore, domain_ready, err_flag}.
    function automatic logic [8:0] expectVec(input logic [2:0] st, input logic err);
        logic en, iso, sv, rs, rdy;
        en  = !((st == S_OFF_REQ) || (st == S_OFF));
        iso = (st != S_ON);
        sv  = (st == S_SAVE);
        rs  = (st == S_RESTORE);
        rdy = (st == S_ON);
        return {st, en, iso, sv, rs, rdy, err};
    endfunction

    task automatic checkOutput(input string tag);
        logic [8:0] obs;
        logic [8:0] expv;
        obs = {pstate, pwr_sw_en, iso_en, save, restore, domain_ready, err_flag};
        tests_run++;
        if (exp_q.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL %s: observed %b, required value missing from queue", tag, obs);
        end else begin
            expv = exp_q.pop_front();
            assert (obs === expv) else begin
                tests_failed++;
                $error("[TB] FAIL %s: observed %b required %b (pstate,en,iso,save,restore,ready,err)",
                       tag, obs, expv);
            end
        end
    endtask

    task automatic applyStimulus(input logic act, input logic wake, input logic ack,
                                 input logic clr, input logic [2:0] st, input logic err,
                                 input string tag);
        activity   = act;
        wake_req   = wake;
        pwr_sw_ack = ack;
        err_clr    = clr;
        exp_q.push_back(expectVec(st, err));
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    // 16 idle cycles from a fresh ON, then the two ISO setup cycles and SAVE.
    task automatic idleToSave(input string tag);
        for (int i = 0; i < 15; i++) applyStimulus(0, 0, 1, 0, S_ON, 0, tag);
        applyStimulus(0, 0, 1, 0, S_ISO, 0, tag);
        applyStimulus(0, 0, 1, 0, S_ISO, 0, tag);
        applyStimulus(0, 0, 1, 0, S_SAVE, 0, tag);
    endtask

    initial begin
        rst_n      = 1'b0;
        activity   = 1'b1;
        wake_req   = 1'b0;
        pwr_sw_ack = 1'b1;
        err_clr    = 1'b0;
        #3;
        exp_q.push_back(expectVec(S_ON, 0));
        checkOutput("reset");
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Idle entry and power-down
        idleToSave("idle_entry");
        applyStimulus(0, 0, 1, 0, S_OFF_REQ, 0, "off_req");
        applyStimulus(0, 0, 0, 0, S_OFF, 0, "off");
        applyStimulus(0, 0, 0, 0, S_OFF, 0, "off_hold");

        // Wake from OFF, ack arrives three cycles after the switch is enabled
        applyStimulus(0, 1, 0, 0, S_ON_REQ, 0, "wake_on_req");
        applyStimulus(0, 0, 0, 0, S_ON_REQ, 0, "wake_wait1");
        applyStimulus(0, 0, 0, 0, S_ON_REQ, 0, "wake_wait2");
        applyStimulus(0, 0, 1, 0, S_RESTORE, 0, "wake_restore");
        applyStimulus(0, 0, 1, 0, S_DEISO, 0, "wake_deiso");
        applyStimulus(1, 0, 1, 0, S_ON, 0, "wake_on");

        // Abort on the first ISO cycle
        for (int i = 0; i < 15; i++) applyStimulus(0, 0, 1, 0, S_ON, 0, "abort_idle");
        applyStimulus(0, 0, 1, 0, S_ISO, 0, "abort_iso");
        applyStimulus(1, 0, 1, 0, S_DEISO, 0, "abort_deiso");
        applyStimulus(1, 0, 1, 0, S_ON, 0, "abort_on");

        // Late wake during SAVE: OFF for exactly one cycle
        idleToSave("late_idle");
        applyStimulus(1, 0, 1, 0, S_OFF_REQ, 0, "late_off_req");
        applyStimulus(0, 0, 0, 0, S_OFF, 0, "late_off");
        applyStimulus(0, 0, 0, 0, S_ON_REQ, 0, "late_on_req");
        applyStimulus(0, 0, 1, 0, S_RESTORE, 0, "late_restore");
        applyStimulus(0, 0, 1, 0, S_DEISO, 0, "late_deiso");
        applyStimulus(1, 0, 1, 0, S_ON, 0, "late_on");

        // Switch-off timeout: ack stays high for 64 OFF_REQ cycles
        idleToSave("to_idle");
        applyStimulus(0, 0, 1, 0, S_OFF_REQ, 0, "to_first");
        for (int i = 0; i < 63; i++) applyStimulus(0, 0, 1, 0, S_OFF_REQ, 0, "to_wait");
        applyStimulus(0, 0, 1, 0, S_ON_REQ, 1, "to_err_set");

        // Switch-on timeout restarts the wait; set beats a same-cycle clear
        applyStimulus(0, 0, 0, 1, S_ON_REQ, 0, "err_clear");
        for (int i = 0; i < 62; i++) applyStimulus(0, 0, 0, 0, S_ON_REQ, 0, "on_req_wait");
        applyStimulus(0, 0, 0, 1, S_ON_REQ, 1, "set_beats_clr");
        applyStimulus(0, 0, 1, 0, S_RESTORE, 1, "err_sticky");
        applyStimulus(0, 0, 1, 1, S_DEISO, 0, "err_clear2");
        applyStimulus(1, 0, 1, 0, S_ON, 0, "to_on");

        // Reset while OFF takes effect without a clock edge
        idleToSave("rst_idle");
        applyStimulus(0, 0, 0, 0, S_OFF_REQ, 0, "rst_off_req");
        applyStimulus(0, 0, 0, 0, S_OFF, 0, "rst_off");
        #2 rst_n = 1'b0;
        #1;
        exp_q.push_back(expectVec(S_ON, 0));
        checkOutput("async_reset");
        activity = 1'b1;
        pwr_sw_ack = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(expectVec(S_ON, 0));
        checkOutput("after_reset");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
